// File: rtl/uart_tx_fifo.sv
// Purpose: UART transmitter with a FIFO and its own baud divider. Words are sent LSB first as start, data, optional parity and stop bits.
// Latency: a word pushed into an empty, idle block pulls tx low on the next clk edge. Queued frames follow each other with no idle cycle.
// Backpressure: data_ready drops while the FIFO holds FIFO_DEPTH words. A full FIFO does not pass a word straight through.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   data_in/data_valid  upstream word; a push happens on data_valid & data_ready
//   data_ready          high when the FIFO has space
//   tx                  registered serial output; idles high
//   busy                high while a frame is in progress or words are queued
//   fifo_count          number of words currently queued
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Parameters are checked at elaboration time, so no initial block is needed.
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_dbits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
        $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count_q;
    logic                 push;
    logic                 pop;
    logic                 fifo_nempty;
    logic [DATA_BITS-1:0] fifo_head;

    assign data_ready  = (count_q != CNT_FULL);
    assign push        = data_valid & data_ready;
    assign fifo_nempty = (count_q != '0);
    assign fifo_head   = mem[rd_ptr];
    assign fifo_count  = count_q;

    // Pointers are AW bits wide and depth is a power of 2, so they wrap by themselves.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The storage array needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    // ----------------------------------------------------------------- FSM
    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par, par_nxt;
    logic                 tx_q, tx_nxt;
    logic                 load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
            par   <= par_nxt;
            tx_q  <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        par_nxt   = par;
        tx_nxt    = tx_q;
        load      = 1'b0;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (fifo_nempty) load = 1'b1;
            end
            START: begin
                if (cnt == BIT_LAST) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        if (PARITY_MODE != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        idx_nxt   = idx + BW'(1);
                        tx_nxt    = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    state_nxt = STOP;
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                // The stop period covers every stop bit in one count.
                if (cnt == STOP_LAST) begin
                    if (fifo_nempty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                tx_nxt    = 1'b1;
            end
        endcase

        // Loading a new frame is shared by IDLE and STOP. Out of STOP it drops tx on
        // the same edge, so queued frames run back to back.
        if (load) begin
            pop       = 1'b1;
            shreg_nxt = fifo_head;
            par_nxt   = (PARITY_MODE == 2) ? ~^fifo_head : ^fifo_head;
            tx_nxt    = 1'b0;
            state_nxt = START;
            cnt_nxt   = '0;
        end
    end

    assign tx   = tx_q;
    assign busy = (state != IDLE) | fifo_nempty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst2;
    logic [7:0] d1, d2;
    logic       v1, v2;
    logic       rdy1, rdy2;
    logic       tx1, tx2;
    logic       busy1, busy2;
    logic [2:0] cnt1, cnt2;

    uart_tx_fifo #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(rst1), .data_in(d1), .data_valid(v1), .data_ready(rdy1),
        .tx(tx1), .busy(busy1), .fifo_count(cnt1)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut2 (
        .clk(clk), .reset(rst2), .data_in(d2), .data_valid(v2), .data_ready(rdy2),
        .tx(tx2), .busy(busy2), .fifo_count(cnt2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic txv(input bit sel);
        return sel ? tx2 : tx1;
    endfunction

    function automatic logic rdyv(input bit sel);
        return sel ? rdy2 : rdy1;
    endfunction

    function automatic logic busyv(input bit sel);
        return sel ? busy2 : busy1;
    endfunction

    task automatic push(input bit sel, input logic [7:0] w);
        bit acc = 1'b0;
        if (sel) begin d2 = w; v2 = 1'b1; end
        else     begin d1 = w; v1 = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            if (rdyv(sel)) begin
                tick();
                acc = 1'b1;
                break;
            end
            tick();
        end
        if (sel) v2 = 1'b0; else v1 = 1'b0;
        `CHK("push_accept", acc, 1'b1);
        if (acc) begin
            if (sel) q2.push_back(w); else q1.push_back(w);
        end
    endtask

    task automatic decode(input bit sel, input int stop_n, output int start_c);
        bit         found = 1'b0;
        logic [7:0] got = '0;
        logic       got_par;
        logic [7:0] exp;
        start_c = 0;
        for (int i = 0; i < 3000; i++) begin
            if (txv(sel) === 1'b0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        `CHK("frame_start_seen", found, 1'b1);
        if (!found) return;
        start_c = cyc;
        tick(); tick();
        `CHK("start_bit", txv(sel), 1'b0);
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 4; j++) tick();
            got[b] = txv(sel);
        end
        for (int j = 0; j < 4; j++) tick();
        got_par = txv(sel);
        for (int s = 0; s < stop_n; s++) begin
            for (int j = 0; j < 4; j++) tick();
            `CHK("stop_bit", txv(sel), 1'b1);
        end
        tick();
        `CHK("busy_last_stop_cycle", busyv(sel), 1'b1);
        `CHK("tx_last_stop_cycle", txv(sel), 1'b1);
        tick();
        if (sel) begin
            `CHK("sb_has_entry", q2.size() != 0, 1'b1);
            if (q2.size() == 0) return;
            exp = q2.pop_front();
            `CHK("frame_data", got, exp);
            `CHK("frame_parity_odd", got_par, ~^exp);
        end else begin
            `CHK("sb_has_entry", q1.size() != 0, 1'b1);
            if (q1.size() == 0) return;
            exp = q1.pop_front();
            `CHK("frame_data", got, exp);
            `CHK("frame_parity_even", got_par, ^exp);
        end
    endtask

    initial begin
        logic [7:0] w;
        logic       pat [11];
        int         st, prev, k, lows;

        rst1 = 1'b1; rst2 = 1'b1;
        d1 = '0; d2 = '0; v1 = 1'b0; v2 = 1'b0;

        tick(); tick(); tick();
        checks++;
        if (tx1 !== 1'b1) begin
            errors++;
            $error("FAIL rst_tx observed=%0b", tx1);
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $error("FAIL rst_busy observed=%0b", busy1);
        end
        checks++;
        if (rdy1 !== 1'b1) begin
            errors++;
            $error("FAIL rst_ready observed=%0b", rdy1);
        end
        checks++;
        if (cnt1 !== 3'd0) begin
            errors++;
            $error("FAIL rst_count observed=%0d", cnt1);
        end
        `CHK("rst_tx_b", tx2, 1'b1);
        `CHK("rst_count_b", cnt2, 3'd0);
        rst1 = 1'b0; rst2 = 1'b0;
        tick();

        push(1'b0, 8'hA5);
        `CHK("push_tx_still_idle", tx1, 1'b1);
        `CHK("push_count", cnt1, 3'd1);
        `CHK("push_busy", busy1, 1'b1);
        tick();
        `CHK("latency_tx_low", tx1, 1'b0);
        `CHK("pop_count", cnt1, 3'd0);
        w = q1.pop_front();
        pat[0] = 1'b0;
        for (int b = 0; b < 8; b++) pat[b+1] = w[b];
        pat[9]  = ^w;
        pat[10] = 1'b1;
        for (int j = 0; j < 44; j++) begin
            checks++;
            if (tx1 !== pat[j/4]) begin
                errors++;
                $error("FAIL a5_tx_c%0d observed=%0b expected=%0b", j, tx1, pat[j/4]);
            end
            if (j == 43) `CHK("a5_busy_end", busy1, 1'b1);
            tick();
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $error("FAIL a5_busy_after observed=%0b", busy1);
        end
        checks++;
        if (tx1 !== 1'b1) begin
            errors++;
            $error("FAIL a5_tx_after observed=%0b", tx1);
        end

        prev = 0;
        fork
            begin
                for (int i = 1; i <= 5; i++) push(1'b0, 8'(i));
                `CHK("full_ready_low", rdy1, 1'b0);
                `CHK("full_count", cnt1, 3'd4);
                push(1'b0, 8'h06);
            end
            begin
                for (int f = 0; f < 6; f++) begin
                    decode(1'b0, 1, st);
                    if (f > 0) `CHK("b2b_gap", st - prev, 44);
                    prev = st;
                end
            end
        join
        `CHK("b2b_busy_after", busy1, 1'b0);

        fork
            push(1'b1, 8'h00);
            decode(1'b1, 2, st);
        join
        `CHK("odd_busy_after", busy2, 1'b0);
        `CHK("odd_tx_after", tx2, 1'b1);

        push(1'b0, 8'h0F);
        k = cyc;
        push(1'b0, 8'h22);
        push(1'b0, 8'h33);
        `CHK("midrst_count_pre", cnt1, 3'd2);
        while (cyc < k + 21) tick();
        `CHK("midrst_tx_pre", tx1, 1'b0);
        rst1 = 1'b1;
        tick();
        `CHK("midrst_tx", tx1, 1'b1);
        `CHK("midrst_count", cnt1, 3'd0);
        `CHK("midrst_busy", busy1, 1'b0);
        `CHK("midrst_ready", rdy1, 1'b1);
        rst1 = 1'b0;
        q1.delete();
        lows = 0;
        for (int j = 0; j < 120; j++) begin
            tick();
            if (tx1 !== 1'b1) lows++;
        end
        `CHK("midrst_no_frames", lows, 0);
        `CHK("midrst_busy_later", busy1, 1'b0);

        prev = 0;
        fork
            begin
                push(1'b0, 8'h3C);
                k = cyc;
                push(1'b0, 8'h5A);
                push(1'b0, 8'h96);
                `CHK("pp_count_pre", cnt1, 3'd2);
                while (cyc < k + 44) tick();
                `CHK("pp_ready_pre", rdy1, 1'b1);
                push(1'b0, 8'hE1);
                `CHK("pp_count", cnt1, 3'd2);
                `CHK("pp_ready", rdy1, 1'b1);
            end
            begin
                for (int f = 0; f < 4; f++) begin
                    decode(1'b0, 1, st);
                    if (f > 0) `CHK("pp_gap", st - prev, 44);
                    prev = st;
                end
            end
        join
        `CHK("pp_busy_after", busy1, 1'b0);
        `CHK("sb_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
